// File: rtl/gamma_sequencer.sv
// Gamma-cycle sequencer: local reset, timed evaluation window,
// first-spike capture per line and a valid/ready result port.
module gamma_sequencer #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int RST_CYCLES = 2,
  parameter int NUM_LINES = 4,
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic                    aclk,
  input  logic                    grst,
  input  logic                    start,
  input  logic                    continuous,
  input  logic [NUM_LINES-1:0]    line_in,
  output logic                    gamma_rst,
  output logic                    eval,
  output logic [TW-1:0]           tick,
  output logic                    busy,
  output logic [NUM_LINES*TW-1:0] res_times,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    overrun
);

  localparam int EVAL_LEN = GAMMA_CYCLE_WIDTH - RST_CYCLES;
  localparam logic [TW-1:0] INF = '1;
  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] EVAL_LAST = TW'(EVAL_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RST,
    S_EVAL
  } state_t;

  state_t state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic [NUM_LINES-1:0] flag_q;
  logic [NUM_LINES-1:0][TW-1:0] cap_q;
  logic [NUM_LINES-1:0][TW-1:0] cap_now;
  logic [NUM_LINES-1:0] hit;
  logic last;

  assign gamma_rst = (state_q == S_RST);
  assign eval = (state_q == S_EVAL);
  assign busy = (state_q != S_IDLE);
  assign tick = eval ? cnt_q : '0;
  assign last = eval && (cnt_q == EVAL_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start || continuous) state_d = S_RST;
      end
      S_RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d = '0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (cnt_q == EVAL_LAST) begin
          cnt_d = '0;
          state_d = continuous ? S_RST : S_IDLE;
        end
      end
      default: begin
        cnt_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // a hit in the final window cycle must reach the result
  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) begin
      hit[i] = eval && line_in[i] && !flag_q[i];
      cap_now[i] = hit[i] ? cnt_q : cap_q[i];
    end
  end

  always_ff @(posedge aclk) begin
    if (grst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      flag_q <= '0;
      cap_q <= '0;
      res_times <= '0;
      res_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (gamma_rst) begin
        flag_q <= '0;
        for (int i = 0; i < NUM_LINES; i++)
          cap_q[i] <= INF;
      end else begin
        for (int i = 0; i < NUM_LINES; i++) begin
          if (hit[i]) begin
            flag_q[i] <= 1'b1;
            cap_q[i] <= cnt_q;
          end
        end
      end
      if (last) begin
        res_times <= cap_now;
        res_valid <= 1'b1;
        if (res_valid && !res_ready) overrun <= 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gamma_sequencer.sv
// Directed bench for gamma_sequencer with default parameters.
// Cycle c is the interval after the c-th rising edge of a scenario.
module tb_gamma_sequencer;

  localparam int TW = 5;
  localparam int NL = 4;

  logic aclk = 1'b0;
  logic grst, start, continuous, res_ready;
  logic [NL-1:0] line_in;
  logic gamma_rst, eval, busy, res_valid, overrun;
  logic [TW-1:0] tick;
  logic [NL*TW-1:0] res_times;

  int errors = 0;
  int checks = 0;

  gamma_sequencer dut (
    .aclk(aclk),
    .grst(grst),
    .start(start),
    .continuous(continuous),
    .line_in(line_in),
    .gamma_rst(gamma_rst),
    .eval(eval),
    .tick(tick),
    .busy(busy),
    .res_times(res_times),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .overrun(overrun)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] pack4(input logic [4:0] l3,
      input logic [4:0] l2, input logic [4:0] l1, input logic [4:0] l0);
    return 32'({l3, l2, l1, l0});
  endfunction

  initial begin
    grst = 1; start = 1; continuous = 0; res_ready = 0; line_in = '0;
    step();
    step();
    check("rst_grst", 32'(gamma_rst), 0);
    check("rst_eval", 32'(eval), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_times", 32'(res_times), 0);
    check("rst_ovr", 32'(overrun), 0);

    // single shot
    for (int c = 0; c <= 18; c++) begin
      grst = 0;
      start = (c == 0);
      res_ready = (c == 17);
      line_in = {1'b0, c == 16, c == 3, c == 6};
      if (c <= 17) begin
        check("ss_grst", 32'(gamma_rst), 32'(c >= 1 && c <= 2));
        check("ss_eval", 32'(eval), 32'(c >= 3 && c <= 16));
        check("ss_tick", 32'(tick), (c >= 3 && c <= 16) ? 32'(c - 3) : 0);
        check("ss_busy", 32'(busy), 32'(c >= 1 && c <= 16));
        check("ss_valid", 32'(res_valid), 32'(c == 17));
      end
      if (c == 17) check("ss_times", 32'(res_times), pack4(31, 13, 0, 3));
      if (c == 18) begin
        check("ss_consumed", 32'(res_valid), 0);
        check("ss_ovr", 32'(overrun), 0);
      end
      if (c < 18) step();
    end

    // first edge wins, start during EVAL ignored
    for (int c = 0; c <= 18; c++) begin
      start = (c == 0) || (c == 8);
      res_ready = (c == 18);
      line_in = {3'b000, c == 5 || c == 6 || c == 10};
      if (c == 17) begin
        check("fe_valid", 32'(res_valid), 1);
        check("fe_times", 32'(res_times), pack4(31, 31, 31, 2));
        check("fe_busy", 32'(busy), 0);
      end
      if (c == 18) begin
        check("fe_no_restart", 32'(gamma_rst), 0);
        check("fe_idle", 32'(busy), 0);
      end
      step();
    end

    // continuous: coincident load+ready, then true overrun
    for (int c = 0; c <= 50; c++) begin
      continuous = 1;
      start = 0;
      res_ready = (c == 32) || (c == 49);
      line_in = {c == 23, c == 35, c == 48, c == 4};
      if (c == 17) begin
        check("ct_valid1", 32'(res_valid), 1);
        check("ct_times1", 32'(res_times), pack4(31, 31, 31, 1));
        check("ct_nogap", 32'(gamma_rst), 1);
      end
      if (c == 33) begin
        check("ct_valid2", 32'(res_valid), 1);
        check("ct_ovr_coinc", 32'(overrun), 0);
        check("ct_times2", 32'(res_times), pack4(4, 31, 31, 31));
      end
      if (c == 49) begin
        check("ct_valid3", 32'(res_valid), 1);
        check("ct_ovr_set", 32'(overrun), 1);
        check("ct_times3", 32'(res_times), pack4(31, 0, 13, 31));
      end
      if (c == 50) begin
        check("ct_consumed", 32'(res_valid), 0);
        check("ct_ovr_sticky", 32'(overrun), 1);
      end
      if (c < 50) step();
    end
    continuous = 0;
    res_ready = 1;
    line_in = '0;
    for (int k = 0; k < 40 && busy; k++) step();
    check("ct_idle_wait", 32'(busy), 0);
    res_ready = 0;

    // reset mid-EVAL
    for (int c = 0; c <= 9; c++) begin
      start = (c == 0);
      grst = (c == 8);
      line_in = {3'b000, c == 4};
      if (c == 8) check("mr_tick5", 32'(tick), 5);
      if (c == 9) begin
        check("mr_busy", 32'(busy), 0);
        check("mr_eval", 32'(eval), 0);
        check("mr_tick", 32'(tick), 0);
        check("mr_valid", 32'(res_valid), 0);
        check("mr_ovr", 32'(overrun), 0);
        check("mr_times", 32'(res_times), 0);
      end
      if (c < 9) step();
    end
    for (int c = 0; c <= 17; c++) begin
      grst = 0;
      start = (c == 0);
      line_in = {1'b0, c == 8, 2'b00};
      if (c == 17) begin
        check("mr2_valid", 32'(res_valid), 1);
        check("mr2_times", 32'(res_times), pack4(31, 5, 31, 31));
      end
      step();
    end
    res_ready = 1;
    step();
    res_ready = 0;

    // continuous stop mid gamma cycle 2
    for (int c = 0; c <= 41; c++) begin
      start = 0;
      continuous = (c < 25);
      res_ready = (c < 32);
      line_in = {2'b00, c == 28, 1'b0};
      if (c == 17) check("cs_rst2", 32'(gamma_rst), 1);
      if (c == 33) begin
        check("cs_valid", 32'(res_valid), 1);
        check("cs_times", 32'(res_times), pack4(31, 31, 9, 31));
        check("cs_ovr", 32'(overrun), 0);
      end
      if (c >= 33) begin
        check("cs_no_grst", 32'(gamma_rst), 0);
        check("cs_idle", 32'(busy), 0);
      end
      if (c < 41) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gamma_sequencer.md
Name: gamma_sequencer

Overview:
- Per-gamma-cycle controller for a bank of temporal (race-logic) primitives such as the not_equal / spike-edge units.
- Generates each gamma cycle's local reset pulse, then opens an evaluation window with a running tick count.
- Records the first-spike time of each datapath output line during the window.
- Presents the time vector to downstream logic through a valid/ready handshake, in single-shot or back-to-back (continuous) mode.

Parameters:
- GAMMA_CYCLE_WIDTH, 16: aclk cycles per gamma cycle, including reset. Must be > RST_CYCLES+1.
- RST_CYCLES, 2: cycles gamma_rst is held high at the start of each gamma cycle. Must be >= 1.
- NUM_LINES, 4: number of datapath output lines timed.
- Derived localparams:
  - EVAL_LEN = GAMMA_CYCLE_WIDTH-RST_CYCLES
  - TW = $clog2(GAMMA_CYCLE_WIDTH)+1
  - INF = all-ones TW-bit value, meaning "no spike"

Ports:
- aclk, input, 1: clock.
- grst, input, 1: synchronous active-high reset.
- start, input, 1: begin one gamma cycle; sampled only in IDLE.
- continuous, input, 1: when high, run back-to-back gamma cycles.
- line_in, input, NUM_LINES: primitive outputs (level/pulse), sampled each aclk.
- gamma_rst, output, 1: local reset to the primitives' rst inputs.
- eval, output, 1: evaluation window open.
- tick, output, TW: time within the window; 0 outside EVAL.
- busy, output, 1: state != IDLE.
- res_times, output, NUM_LINES*TW: first-spike times; line i occupies bits [i*TW +: TW].
- res_valid, output, 1: result available.
- res_ready, input, 1: consumer accepts the result.
- overrun, output, 1: sticky flag; an unconsumed result was overwritten.

Behaviour:
- Reset is synchronous: grst=1 at a rising aclk edge forces state IDLE and clears all outputs and internal registers to 0 (res_times=0, overrun=0) from the next cycle. This holds mid-operation; any in-flight capture is discarded.
- FSM states: IDLE, RESET, EVAL.
  - IDLE: start=1 or continuous=1 -> RESET.
  - RESET: gamma_rst=1 for exactly RST_CYCLES cycles -> EVAL. All capture flags clear and capture times are set to INF.
  - EVAL: eval=1 for exactly EVAL_LEN cycles, tick counts 0..EVAL_LEN-1.
    - After the last EVAL cycle: continuous=1 -> RESET (no idle gap); otherwise -> IDLE.
- start is ignored while busy=1. Deasserting continuous mid-cycle finishes the current gamma cycle and then returns to IDLE.
- Latency: start sampled in cycle t gives gamma_rst high in cycles t+1..t+RST_CYCLES and EVAL in cycles t+RST_CYCLES+1..t+GAMMA_CYCLE_WIDTH. res_valid rises in cycle t+GAMMA_CYCLE_WIDTH+1.
- Capture: in an EVAL cycle, if line_in[i]=1 and the line's flag is clear, store the current tick and set the flag. Later highs on that line are ignored (first edge wins). A line never high stays INF. A line high during RESET is not captured.
- Result load: in the last EVAL cycle, capture values (including a hit in that same cycle) are loaded into res_times, and res_valid=1 from the next cycle.
- Handshake: res_valid stays high until a cycle with res_ready=1. res_times is stable while res_valid=1, unless overwritten by a new load.
- Load while res_valid=1:
  - If res_ready=0 that cycle: the new result overwrites, res_valid stays 1, overrun sets.
  - If res_ready=1 that cycle: the old result is consumed, the new one is loaded, res_valid stays 1, and overrun does not set.
- overrun clears only on grst.
- The sequencer never stalls on res_ready.

Test Plan:
- Setup for all scenarios: defaults (GAMMA_CYCLE_WIDTH=16, RST_CYCLES=2, NUM_LINES=4, EVAL_LEN=14, TW=5, INF=31).
- Reset: hold grst 2 cycles with start=1 -> all outputs 0, busy=0; release grst -> start in the next cycle is accepted.
- Single shot:
  - Stimulus: start at cycle 0; line1 high at tick 0 (cycle 3), line0 at tick 3, line2 at tick 13 (cycle 16), line3 never.
  - Response: gamma_rst=1 in cycles 1-2; eval in cycles 3-16; res_valid=1 at cycle 17; res_times = {31,13,0,3} (line3..line0); busy=0 at cycle 17.
- First-edge: line0 high at tick 2, low at tick 4, high at tick 7 -> time 2; start pulsed during EVAL -> ignored.
- Continuous overrun: continuous=1, res_ready=0 for 2 gamma cycles -> second result shown, overrun=1; res_ready=1 for one cycle -> res_valid=0, overrun stays 1. Load coincident with res_ready=1 -> overrun unchanged.
- Reset mid-EVAL: grst at tick 5 -> next cycle IDLE, res_valid=0, eval=0, tick=0; a subsequent start yields a correct, unpolluted result.
- Continuous stop: deassert continuous at tick 6 of gamma cycle 2 -> that cycle completes and its result is delivered, then IDLE with no further gamma_rst.
